multicycle_ctrl: RTL and testbench

Multicycle control unit that sequences the 8-bit/16-bit-instruction datapath through fetch, decode, execute, memory and writeback. It drives every datapath select and enable, including regdst, alusrc, memtoreg, regwrite, pcsrc, jump and alucontrol. It also runs req/ready handshakes with the instruction and data memories, and traps HALT, illegal opcodes and memory timeouts. It sits beside the datapath inside the processor top and replaces single-cycle decode.

---
 rtl/multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB, runs imem/dmem handshakes and
// traps HALT, illegal opcodes and memory timeouts. Define PERF_CNT_EN to add perf counters.
module multicycle_ctrl #(
  parameter int IWIDTH  = 16,
  parameter int TIMEOUT = 15,
  parameter int CWIDTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IWIDTH-1:0] instr,
  input  logic              zero,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic              irwrite,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ready,
  output logic              pcen,
  output logic              memtoreg,
  output logic              pcsrc,
  output logic              alusrc,
  output logic              regdst,
  output logic              regwrite,
  output logic              jump,
  output logic [3:0]        alucontrol,
  output logic              halted,
  output logic              error
`ifdef PERF_CNT_EN
  , output logic [CWIDTH-1:0] cycle_cnt
  , output logic [CWIDTH-1:0] retire_cnt
`endif
);

  localparam logic [2:0] StRst    = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StHalt   = 3'd6;
  localparam logic [2:0] StErr    = 3'd7;

  localparam logic [3:0] OpR    = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpLw   = 4'h2;
  localparam logic [3:0] OpSw   = 4'h3;
  localparam logic [3:0] OpBeq  = 4'h4;
  localparam logic [3:0] OpJ    = 4'h5;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;

  localparam int CntW = $clog2(TIMEOUT + 1);

  logic [2:0]      state_q, state_d;
  logic [3:0]      op_q, funct_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic is_r, is_addi, is_lw, is_sw, is_beq, is_j, is_halt, is_legal;
  logic waiting, timeout_hit;
  logic [3:0] alu_op;
  logic alu_src_reg;

  if (IWIDTH > 8) begin : g_unused
    logic unused_mid;
    assign unused_mid = ^instr[IWIDTH-5:4];
  end

  // Decode only the copy latched on irwrite so live instr changes cannot disturb control.
  assign is_r     = (op_q == OpR);
  assign is_addi  = (op_q == OpAddi);
  assign is_lw    = (op_q == OpLw);
  assign is_sw    = (op_q == OpSw);
  assign is_beq   = (op_q == OpBeq);
  assign is_j     = (op_q == OpJ);
  assign is_halt  = (op_q == OpHalt);
  assign is_legal = is_r | is_addi | is_lw | is_sw | is_beq | is_j;

  always_comb begin
    alu_op      = 4'b0000;
    alu_src_reg = 1'b0;
    if (is_r) begin
      alu_op      = funct_q;
      alu_src_reg = 1'b1;
    end else if (is_addi || is_lw || is_sw) begin
      alu_op = AluAdd;
    end else if (is_beq) begin
      alu_op      = AluSub;
      alu_src_reg = 1'b1;
    end
  end

  assign waiting     = ((state_q == StFetch) && !imem_ready) ||
                       ((state_q == StMem) && !dmem_ready);
  // A ready in the cycle the count reaches TIMEOUT is checked first and wins.
  assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRst:   state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          state_d = StDecode;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StDecode: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (!is_legal) begin
          state_d = StErr;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_r || is_addi) begin
          state_d = StWb;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = is_lw ? StWb : StFetch;
        end else if (timeout_hit) begin
          state_d = StErr;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StErr:   state_d = StErr;
      default: state_d = StRst;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q    <= 4'h0;
      funct_q <= 4'h0;
    end else if (irwrite) begin
      op_q    <= instr[IWIDTH-1:IWIDTH-4];
      funct_q <= instr[3:0];
    end
  end

  // Outputs depend on state_q, so they fall with the asynchronous state clear.
  always_comb begin
    imem_req   = 1'b0;
    irwrite    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pcen       = 1'b0;
    memtoreg   = 1'b0;
    pcsrc      = 1'b0;
    alusrc     = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    jump       = 1'b0;
    alucontrol = 4'b0000;
    halted     = 1'b0;
    error      = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        irwrite  = imem_ready;
      end
      StExec: begin
        alucontrol = alu_op;
        alusrc     = alu_src_reg;
        regdst     = is_r;
        if (is_beq) begin
          pcsrc = zero;
          pcen  = 1'b1;
        end
        if (is_j) begin
          jump = 1'b1;
          pcen = 1'b1;
        end
      end
      StMem: begin
        dmem_req   = 1'b1;
        dmem_we    = is_sw;
        alucontrol = AluAdd;
        alusrc     = 1'b0;
        pcen       = is_sw & dmem_ready;
      end
      StWb: begin
        regwrite   = 1'b1;
        pcen       = 1'b1;
        memtoreg   = is_lw;
        regdst     = is_r;
        alucontrol = alu_op;
        alusrc     = alu_src_reg;
      end
      StHalt:  halted = 1'b1;
      StErr:   error  = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [CWIDTH-1:0] cycle_q, retire_q;
  logic              active;

  assign active = (state_q != StRst) && (state_q != StHalt) && (state_q != StErr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q  <= '0;
      retire_q <= '0;
    end else begin
      if (active && !(&cycle_q)) begin
        cycle_q <= cycle_q + 1'b1;
      end
      if (pcen && !(&retire_q)) begin
        retire_q <= retire_q + 1'b1;
      end
    end
  end

  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle stimulus and expected control vectors are
// queued from a per-instruction model, then applied and compared one cycle at a time.
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = 16'h0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, irwrite, dmem_req, dmem_we, pcen, memtoreg, pcsrc, alusrc;
  logic        regdst, regwrite, jump, halted, error;
  logic [3:0]  alucontrol;
  logic [16:0] obs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.IWIDTH(16), .TIMEOUT(TIMEOUT), .CWIDTH(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero),
    .imem_req(imem_req), .imem_ready(imem_ready), .irwrite(irwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .pcen(pcen), .memtoreg(memtoreg), .pcsrc(pcsrc), .alusrc(alusrc),
    .regdst(regdst), .regwrite(regwrite), .jump(jump), .alucontrol(alucontrol),
    .halted(halted), .error(error)
  );

  assign obs = {imem_req, irwrite, dmem_req, dmem_we, pcen, memtoreg, pcsrc, alusrc,
                regdst, regwrite, jump, alucontrol, halted, error};

  typedef struct packed {
    logic        rst;
    logic        ir;
    logic        dr;
    logic        z;
    logic [15:0] ins;
    logic [16:0] exp;
  } step_t;

  step_t sb[$];
  int checks = 0;
  int errors = 0;
  int step_n = 0;
  int pcen_seen = 0;
  int retire_exp = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [16:0] mk(input logic ireq, irw, dreq, dwe, pce, m2r, psrc, asrc,
                                     rdst, rw, jmp, input logic [3:0] alu,
                                     input logic hlt, err);
    return {ireq, irw, dreq, dwe, pce, m2r, psrc, asrc, rdst, rw, jmp, alu, hlt, err};
  endfunction

  task automatic push(input logic rst, ir, dr, z, input logic [15:0] ins,
                      input logic [16:0] exp);
    step_t s;
    s.rst = rst; s.ir = ir; s.dr = dr; s.z = z; s.ins = ins; s.exp = exp;
    sb.push_back(s);
    if (exp[12]) retire_exp++;
  endtask

  task automatic drain(input string tag);
    step_t s;
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk);
      reset = s.rst; imem_ready = s.ir; dmem_ready = s.dr; zero = s.z; instr = s.ins;
      #1;
      if (pcen === 1'b1) pcen_seen++;
      check($sformatf("%s[%0d]", tag, step_n), {15'b0, obs}, {15'b0, s.exp});
      step_n++;
    end
  endtask

  task automatic push_reset(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b1, 1'b1, 1'b0, 16'($urandom), '0);
    push(1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom), '0);
  endtask

  task automatic push_fetch(input logic [15:0] ins, input logic z, input int fwait);
    for (int i = 0; i < fwait; i++)
      push(1'b1, 1'b0, 1'b1, z, 16'($urandom), mk(1,0,0,0,0,0,0,0,0,0,0,4'h0,0,0));
    push(1'b1, 1'b1, 1'b1, z, ins, mk(1,1,0,0,0,0,0,0,0,0,0,4'h0,0,0));
    push(1'b1, 1'b1, 1'b1, z, 16'($urandom), '0);
  endtask

  // Expected ALU selects: R uses funct with register operand, ADDI/LW/SW add-immediate, BEQ sub.
  task automatic alu_of(input logic [15:0] ins, output logic [3:0] alu, output logic asrc);
    case (ins[15:12])
      4'h0:              begin alu = ins[3:0]; asrc = 1'b1; end
      4'h1, 4'h2, 4'h3:  begin alu = 4'b0010;  asrc = 1'b0; end
      4'h4:              begin alu = 4'b0110;  asrc = 1'b1; end
      default:           begin alu = 4'b0000;  asrc = 1'b0; end
    endcase
  endtask

  task automatic push_exec(input logic [15:0] ins, input logic z);
    logic [3:0] op, alu;
    logic asrc, br;
    op = ins[15:12];
    alu_of(ins, alu, asrc);
    br = (op == 4'h4) || (op == 4'h5);
    push(1'b1, 1'b1, 1'b1, z, 16'($urandom),
         mk(0,0,0,0, br, 0, (op == 4'h4) & z, asrc, op == 4'h0, 0, op == 4'h5, alu, 0,0));
  endtask

  task automatic push_mem_wait(input logic sw, input logic z, input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b1, 1'b0, z, 16'($urandom), mk(0,0,1,sw,0,0,0,0,0,0,0,4'b0010,0,0));
  endtask

  task automatic push_instr(input logic [15:0] ins, input logic z, input int fwait,
                            input int mwait);
    logic [3:0] op, alu;
    logic asrc, lw, sw;
    op = ins[15:12];
    lw = (op == 4'h2);
    sw = (op == 4'h3);
    alu_of(ins, alu, asrc);
    push_fetch(ins, z, fwait);
    push_exec(ins, z);
    if (lw || sw) begin
      push_mem_wait(sw, z, mwait);
      push(1'b1, 1'b1, 1'b1, z, 16'($urandom), mk(0,0,1,sw,sw,0,0,0,0,0,0,4'b0010,0,0));
    end
    if (op == 4'h0 || op == 4'h1 || lw)
      push(1'b1, 1'b1, 1'b1, z, 16'($urandom),
           mk(0,0,0,0,1, lw, 0, asrc, op == 4'h0, 1, 0, alu, 0,0));
  endtask

  task automatic push_trapped(input logic hlt, input int n);
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom), mk(0,0,0,0,0,0,0,0,0,0,0,4'h0, hlt, !hlt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] illegal_ops[4];
    illegal_ops[0] = 16'h7000; illegal_ops[1] = 16'h6123;
    illegal_ops[2] = 16'h8000; illegal_ops[3] = 16'hE00F;

    push_reset(3);
    push_instr(16'h0002, 1'b0, 0, 0);
    push_instr(16'h0007, 1'b0, 2, 0);
    push_instr(16'h1123, 1'b0, 0, 0);
    drain("rtype_addi");

    push_instr(16'h2005, 1'b0, 0, 3);
    push_instr(16'h2005, 1'b0, 0, 0);
    drain("lw");

    push_instr(16'h4003, 1'b1, 0, 0);
    push_instr(16'h4003, 1'b0, 0, 0);
    drain("beq");

    push_instr(16'h5010, 1'b0, 0, 0);
    push_instr(16'h3004, 1'b0, 0, 2);
    push_instr(16'h3004, 1'b0, 1, 0);
    drain("j_sw");

    foreach (illegal_ops[k]) begin
      push_reset(2);
      push_fetch(illegal_ops[k], 1'b0, 0);
      push_trapped(1'b0, (k == 0) ? 20 : 4);
    end
    drain("illegal");

    push_reset(2);
    push_fetch(16'hF000, 1'b0, 0);
    push_trapped(1'b1, 20);
    drain("halt");

    push_reset(2);
    push_fetch(16'h2005, 1'b0, 0);
    push_exec(16'h2005, 1'b0);
    push_mem_wait(1'b0, 1'b0, TIMEOUT);
    push_trapped(1'b0, 5);
    drain("mem_timeout");

    push_reset(2);
    push_instr(16'h3004, 1'b0, 0, TIMEOUT - 1);
    push_instr(16'h2005, 1'b0, TIMEOUT - 1, TIMEOUT - 1);
    drain("ready_at_limit");

    push_reset(2);
    for (int i = 0; i < TIMEOUT; i++)
      push(1'b1, 1'b0, 1'b1, 1'b0, 16'($urandom), mk(1,0,0,0,0,0,0,0,0,0,0,4'h0,0,0));
    push_trapped(1'b0, 5);
    drain("fetch_timeout");

    push_reset(2);
    push_fetch(16'h2005, 1'b0, 0);
    push_exec(16'h2005, 1'b0);
    push_mem_wait(1'b0, 1'b0, 3);
    drain("mid_mem");
    check("mid_mem_req_high", {31'b0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_drop", {28'b0, dmem_req, pcen, regwrite, imem_req}, 32'd0);

    push_reset(2);
    push_instr(16'h0002, 1'b0, 0, 0);
    drain("restart");

    check("retire_count", pcen_seen, retire_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
